// File: rtl/hex_scroll_pkg.sv
// hex_scroll_pkg: shared types for the hex scroll buffer.
//   state_e             - display/scroll state
//   digit_t             - one hex digit
//   STEP_CYCLES_DEFAULT - default clock cycles per scroll step (0.25 s at 12 MHz)
package hex_scroll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STATIC,
    ST_SCROLL,
    ST_HOLD
  } state_e;

  typedef logic [3:0] digit_t;

  localparam int unsigned STEP_CYCLES_DEFAULT = 3000000;

endpackage

// File: rtl/hex_scroll_buffer_prescaler.sv
// scroll_prescaler: down-counter that produces one tick every STEP_CYCLES
// enabled cycles.
//   CLK    - clock
//   RST_N  - asynchronous active-low reset (counter loads STEP_CYCLES-1)
//   enable - count this cycle; when disabled the count is frozen
//   reload - force the counter back to STEP_CYCLES-1 (overrides enable)
//   tick   - high for the enabled cycle in which the count is 0
module scroll_prescaler
  import hex_scroll_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic enable,
  input  logic reload,
  output logic tick
);

  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (reload) begin
      cnt_d = RELOAD_VAL;
    end else if (enable) begin
      if (cnt_q == '0) begin
        cnt_d = RELOAD_VAL;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= RELOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_scroll_buffer.sv
// hex_scroll_buffer: stores up to DEPTH hex digits and presents a four-digit
// window of them, scrolling through the message when it is longer than four
// digits.
//   CLK, RST_N - clock, asynchronous active-low reset
//   WR_EN      - append WR_DATA at index LEN (dropped when FULL or CLR)
//   WR_DATA    - hex digit to append
//   CLR        - synchronous clear of the message, pointer and prescaler
//   RUN        - scrolling enabled
//   DIR        - 0: pointer increments (scroll left), 1: pointer decrements
//   WINDOW     - four displayed digits, [15:12] leftmost
//   LEN        - number of stored digits
//   FULL       - LEN == DEPTH
//   STEP       - one-cycle pulse in the cycle a scroll step is taken
module hex_scroll_buffer
  import hex_scroll_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     WR_EN,
  input  logic [3:0]               WR_DATA,
  input  logic                     CLR,
  input  logic                     RUN,
  input  logic                     DIR,
  output logic [15:0]              WINDOW,
  output logic [$clog2(DEPTH):0]   LEN,
  output logic                     FULL,
  output logic                     STEP
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  digit_t        mem_q [DEPTH];
  digit_t        mem_d [DEPTH];
  logic [AW:0]   len_q;
  logic [AW:0]   len_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  state_e        state_q;
  state_e        state_d;

  logic          wr_ok;
  logic          step_tick;
  logic          presc_enable;
  logic          presc_reload;

  // Prescaler only runs while scrolling; it is held at its reload value in
  // IDLE/STATIC so that a new scroll always starts with a full step period,
  // and simply frozen in HOLD so a paused scroll resumes mid-period.
  assign presc_enable = (state_q == ST_SCROLL);
  assign presc_reload = CLR || (state_q == ST_IDLE) || (state_q == ST_STATIC);

  scroll_prescaler #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_prescaler (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .enable (presc_enable),
    .reload (presc_reload),
    .tick   (step_tick)
  );

  // Next-state: the step wraps against the pre-write length so a write in
  // the same cycle never pulls the pointer onto the new digit early.
  always_comb begin
    mem_d   = mem_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    state_d = state_q;
    wr_ok   = WR_EN && !CLR && (len_q != DEPTH_L);

    if (CLR) begin
      len_d = '0;
      ptr_d = '0;
    end else begin
      if (wr_ok) begin
        mem_d[len_q[AW-1:0]] = WR_DATA;
        len_d = len_q + (AW+1)'(1);
      end
      if (step_tick) begin
        if (DIR) begin
          ptr_d = (ptr_q == '0) ? AW'(len_q - (AW+1)'(1)) : ptr_q - AW'(1);
        end else begin
          ptr_d = ({1'b0, ptr_q} == len_q - (AW+1)'(1)) ? '0 : ptr_q + AW'(1);
        end
      end
    end

    if (len_d == '0) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
    end else if (len_d <= (AW+1)'(4)) begin
      state_d = ST_STATIC;
      ptr_d   = '0;
    end else if (RUN) begin
      state_d = ST_SCROLL;
    end else begin
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_q   <= '{default: '0};
      len_q   <= '0;
      ptr_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      mem_q   <= mem_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
    end
  end

  // Window decode. When scrolling LEN > 4, so ptr+i (ptr < LEN, i < 4) needs
  // at most one subtraction of LEN to stay in range.
  always_comb begin
    int unsigned len_i;
    int unsigned idx;
    WINDOW = '0;
    len_i  = int'(len_q);
    idx    = 0;
    case (state_q)
      ST_STATIC: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (i + len_i >= 4) begin
            idx = i + len_i - 4;
            WINDOW[15 - 4*i -: 4] = mem_q[AW'(idx)];
          end
        end
      end
      ST_SCROLL, ST_HOLD: begin
        for (int unsigned i = 0; i < 4; i++) begin
          idx = int'(ptr_q) + i;
          if (idx >= len_i) begin
            idx = idx - len_i;
          end
          WINDOW[15 - 4*i -: 4] = mem_q[AW'(idx)];
        end
      end
      default: WINDOW = '0;
    endcase
  end

  assign LEN  = len_q;
  assign FULL = (len_q == DEPTH_L);
  assign STEP = step_tick;

endmodule

// File: doc/hex_scroll_buffer.md
HEX_SCROLL_BUFFER -- requirements
Module: hex_scroll_buffer

Interface
REQ-001 Parameter DEPTH, default 16: message capacity in hex digits; power of two, at least 8.
REQ-002 Parameter STEP_CYCLES, default 3000000: CLK cycles per scroll step (0.25 s at 12 MHz).
REQ-003 Port CLK  in  1: single clock; all state updates on its rising edge.
REQ-004 Port RST_N  in  1: reset, asynchronous, active-low.
REQ-005 Port WR_EN  in  1: append WR_DATA to the message this cycle.
REQ-006 Port WR_DATA  in  4: hex digit to append.
REQ-007 Port CLR  in  1: synchronous message clear.
REQ-008 Port RUN  in  1: scrolling enabled.
REQ-009 Port DIR  in  1: 0 = scroll left (pointer increments), 1 = scroll right (pointer decrements).
REQ-010 Port WINDOW  out  16: four displayed digits; [15:12] is leftmost; feeds the 7-segment digit multiplexer.
REQ-011 Port LEN  out  clog2(DEPTH)+1: number of stored digits.
REQ-012 Port FULL  out  1: LEN == DEPTH.
REQ-013 Port STEP  out  1: one-cycle pulse on each scroll step.

Function
REQ-014 The buffer SHALL append each write at index LEN and increment LEN; a write when FULL is dropped, leaving all state unchanged.
REQ-015 CLR SHALL set LEN=0, ptr=0, and reload the prescaler; when CLR and WR_EN coincide, CLR wins and the write is dropped.
REQ-016 The FSM SHALL use states IDLE (LEN=0), STATIC (1<=LEN<=4), SCROLL (LEN>4 and RUN), and HOLD (LEN>4 and !RUN), re-evaluated every cycle from post-update LEN and RUN.
REQ-017 In IDLE, WINDOW SHALL be 16'h0000.
REQ-018 In STATIC, WINDOW SHALL show digits 0..LEN-1 right-justified, with unused leading digits at 0 (e.g. LEN=2 of a,b -> 16'h00ab), and ptr held at 0.
REQ-019 In SCROLL/HOLD, WINDOW digit i (i=0 leftmost) SHALL be buf[(ptr+i) mod LEN].
REQ-020 WINDOW SHALL be combinational from registered state; a change made at edge k is visible directly after edge k.
REQ-021 The prescaler SHALL count STEP_CYCLES-1 down to 0 only in SCROLL; at 0 it reloads, STEP=1 for that cycle, and ptr moves by one mod LEN in direction DIR.
REQ-022 In HOLD, the prescaler SHALL freeze and resume its remaining count on return to SCROLL.
REQ-023 Entering SCROLL from STATIC SHALL start with the prescaler at STEP_CYCLES-1 and ptr=0.
REQ-024 A DIR change SHALL take effect at the next step; the pointer never jumps.
REQ-025 A write coinciding with a step SHALL have both take effect, and the step modulus SHALL use the pre-write LEN.
REQ-026 Pointer wrap SHALL be LEN-1 -> 0 (DIR=0) and 0 -> LEN-1 (DIR=1), with no out-of-range index ever produced.

Reset
REQ-027 On RST_N low, asynchronously: LEN=0, ptr=0, buffer=0, prescaler=STEP_CYCLES-1, state IDLE, WINDOW=0, STEP=0, FULL=0.
REQ-028 Reset asserted mid-scroll SHALL take effect without waiting for CLK, and operation SHALL resume from IDLE on the first edge after release.

Structure
REQ-029 Package hex_scroll_pkg SHALL hold the state enum, the 4-bit digit type, and the STEP_CYCLES default.
REQ-030 The prescaler SHALL be sub-module scroll_prescaler (ports: CLK, RST_N, enable, reload, tick).
REQ-031 The digit store SHALL be a register array.

Verification (STEP_CYCLES=4, DEPTH=16)
REQ-032 Reset, then write 1,2 -> WINDOW=16'h0012, LEN=2, STEP never pulses.
REQ-033 Write 0..5, RUN=1, DIR=0 -> WINDOW 0123, then every 4 cycles 1234, 2345, 3450, 4501, 5012, 0123 with STEP each time.
REQ-034 Same message at ptr=0 with DIR=1 -> first step gives 5012; then drop RUN after 2 cycles, wait 10, raise RUN -> next step 2 cycles later.
REQ-035 Write 17 digits -> LEN=16, FULL=1, 17th digit absent from all windows; then CLR with WR_EN -> LEN=0, WINDOW=0.
REQ-036 Pull RST_N low between edges mid-scroll -> WINDOW=0 and LEN=0 before the next edge.
